regfile_scoreboard: RTL and testbench

Decode-side register file with a pending-write scoreboard. It is the receiving end of the writeback interface: it commits O_WriteBackEnable/RegIdx/Data from the writeback stage into 16 architectural registers. It serves two bypassed read ports to decode and generates the dependency stall that decode forwards down the pipe as I_DepStall.

---
 rtl/regfile_scoreboard_pkg.sv | 30 +++
 rtl/regfile_scoreboard_if.sv | 41 ++++
 rtl/regfile_scoreboard_pend.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 112 +++++++++++
 tb/tb_regfile_scoreboard.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths, types and the counter-op helper for the
// decode-side register file and its pending-write scoreboard.
package regfile_scoreboard_pkg;

    localparam int NUM_REGS     = 16;
    localparam int REGIDX_WIDTH = 4;
    localparam int PEND_WIDTH   = 2;
    localparam int REG_WIDTH    = 16;

    typedef logic [REG_WIDTH-1:0]    reg_t;
    typedef logic [REGIDX_WIDTH-1:0] idx_t;
    typedef logic [PEND_WIDTH-1:0]   pend_t;

    localparam pend_t PEND_MAX = 2'd3;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        if (inc && !dec)
            return CNT_INC;
        if (dec && !inc)
            return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback commit and decode issue/read bundle between the
// pipeline (master) and the register file scoreboard (slave).
interface regfile_scoreboard_if;
    import regfile_scoreboard_pkg::*;

    logic I_WriteBackEnable;
    idx_t I_WriteBackRegIdx;
    reg_t I_WriteBackData;

    logic I_IssueValid;
    logic I_Src1Valid;
    logic I_Src2Valid;
    idx_t I_Src1Idx;
    idx_t I_Src2Idx;
    logic I_DestValid;
    idx_t I_DestIdx;

    reg_t O_Src1Data;
    reg_t O_Src2Data;
    logic O_DepStall;
    logic O_IssueAccept;
    logic O_SbIdle;
    logic O_Underflow;

    modport master (
        output I_WriteBackEnable, I_WriteBackRegIdx, I_WriteBackData,
        output I_IssueValid, I_Src1Valid, I_Src2Valid,
        output I_Src1Idx, I_Src2Idx, I_DestValid, I_DestIdx,
        input  O_Src1Data, O_Src2Data, O_DepStall,
        input  O_IssueAccept, O_SbIdle, O_Underflow
    );

    modport slave (
        input  I_WriteBackEnable, I_WriteBackRegIdx, I_WriteBackData,
        input  I_IssueValid, I_Src1Valid, I_Src2Valid,
        input  I_Src1Idx, I_Src2Idx, I_DestValid, I_DestIdx,
        output O_Src1Data, O_Src2Data, O_DepStall,
        output O_IssueAccept, O_SbIdle, O_Underflow
    );

endinterface

// File: rtl/regfile_scoreboard_pend.sv
// Per-register in-flight write counter: saturating up/down,
// frozen while lock is low, cleared by async reset.
module sb_pend_counter
    import regfile_scoreboard_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  lock,
    input  logic  inc,
    input  logic  dec,
    output pend_t count
);

    pend_t count_q;
    pend_t count_d;

    always_comb begin
        count_d = count_q;
        if (lock) begin
            unique case (cnt_op(inc, dec))
                CNT_INC: begin
                    if (count_q != PEND_MAX)
                        count_d = pend_t'(count_q + 2'd1);
                end
                CNT_DEC: begin
                    if (count_q != '0)
                        count_d = pend_t'(count_q - 2'd1);
                end
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-through read bypass and a pending-write
// scoreboard that raises the decode dependency stall.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                 I_CLOCK,
    input  logic                 I_RESET_N,
    input  logic                 I_LOCK,
    regfile_scoreboard_if.slave  bus
);

    reg_t  regs_q [NUM_REGS];
    reg_t  regs_d [NUM_REGS];
    pend_t pend   [NUM_REGS];

    logic                wr_en;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] retire;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                src1_hz;
    logic                src2_hz;
    logic                dest_sat;
    logic                stall;
    logic                accept;
    logic                idle;
    logic                underflow_q;
    logic                underflow_d;

    assign wr_en = I_LOCK & bus.I_WriteBackEnable;

    always_comb begin
        wr_hit = '0;
        retire = '0;
        inc    = '0;
        dec    = '0;
        idle   = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_hit[r] = wr_en && (bus.I_WriteBackRegIdx == idx_t'(r));
            retire[r] = wr_hit[r] && (pend[r] == 2'd1);
            dec[r]    = wr_hit[r] && (pend[r] != '0);
            inc[r]    = accept && bus.I_DestValid
                        && (bus.I_DestIdx == idx_t'(r));
            if (pend[r] != '0)
                idle = 1'b0;
        end
    end

    // A final commit to a source releases the stall in the same cycle.
    always_comb begin
        src1_hz  = bus.I_Src1Valid
                   && (pend[bus.I_Src1Idx] != '0)
                   && !retire[bus.I_Src1Idx];
        src2_hz  = bus.I_Src2Valid
                   && (pend[bus.I_Src2Idx] != '0)
                   && !retire[bus.I_Src2Idx];
        dest_sat = bus.I_DestValid
                   && (pend[bus.I_DestIdx] == PEND_MAX)
                   && !wr_hit[bus.I_DestIdx];
        stall    = bus.I_IssueValid && (src1_hz || src2_hz || dest_sat);
        accept   = I_LOCK && bus.I_IssueValid && !stall;
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            regs_d[r] = regs_q[r];
        if (wr_en)
            regs_d[bus.I_WriteBackRegIdx] = bus.I_WriteBackData;
    end

    always_comb begin
        underflow_d = underflow_q;
        if (wr_en && (pend[bus.I_WriteBackRegIdx] == '0))
            underflow_d = 1'b1;
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_q[r] <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_q[r] <= regs_d[r];
            underflow_q <= underflow_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        sb_pend_counter u_cnt (
            .clk   (I_CLOCK),
            .rst_n (I_RESET_N),
            .lock  (I_LOCK),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .count (pend[g])
        );
    end

    assign bus.O_Src1Data = wr_hit[bus.I_Src1Idx]
                            ? bus.I_WriteBackData
                            : regs_q[bus.I_Src1Idx];
    assign bus.O_Src2Data = wr_hit[bus.I_Src2Idx]
                            ? bus.I_WriteBackData
                            : regs_q[bus.I_Src2Idx];

    assign bus.O_DepStall    = stall;
    assign bus.O_IssueAccept = accept;
    assign bus.O_SbIdle      = idle;
    assign bus.O_Underflow   = underflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: driver pushes model predictions, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_regfile_scoreboard;

    logic clk;
    logic rst_n;
    logic lock;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .I_CLOCK   (clk),
        .I_RESET_N (rst_n),
        .I_LOCK    (lock),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        accept;
        logic [15:0] src1;
        logic [15:0] src2;
        logic        idle;
        logic        uf;
    } exp_t;

    exp_t q[$];

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    logic [15:0] m_reg [16];
    int          m_pend[16];
    logic        m_uf;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",  {15'd0, bus.O_DepStall},    {15'd0, e.stall});
            chk("accept", {15'd0, bus.O_IssueAccept}, {15'd0, e.accept});
            chk("src1",   bus.O_Src1Data,             e.src1);
            chk("src2",   bus.O_Src2Data,             e.src2);
            chk("idle",   {15'd0, bus.O_SbIdle},      {15'd0, e.idle});
            chk("uflow",  {15'd0, bus.O_Underflow},   {15'd0, e.uf});
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
        m_uf = 1'b0;
    endfunction

    // Predict this cycle's outputs from current inputs, then advance model.
    task automatic predict_and_advance(input logic do_edge);
        exp_t e;
        logic we;
        logic h1, h2, sat;
        int   s1, s2, d, w;
        we = lock && bus.I_WriteBackEnable;
        s1 = int'(bus.I_Src1Idx);
        s2 = int'(bus.I_Src2Idx);
        d  = int'(bus.I_DestIdx);
        w  = int'(bus.I_WriteBackRegIdx);
        e.src1 = (we && w == s1) ? bus.I_WriteBackData : m_reg[s1];
        e.src2 = (we && w == s2) ? bus.I_WriteBackData : m_reg[s2];
        h1 = bus.I_Src1Valid && m_pend[s1] > 0
             && !(we && w == s1 && m_pend[s1] == 1);
        h2 = bus.I_Src2Valid && m_pend[s2] > 0
             && !(we && w == s2 && m_pend[s2] == 1);
        sat = bus.I_DestValid && m_pend[d] == 3 && !(we && w == d);
        e.stall  = bus.I_IssueValid && (h1 || h2 || sat);
        e.accept = lock && bus.I_IssueValid && !e.stall;
        e.idle   = 1'b1;
        for (int i = 0; i < 16; i++)
            if (m_pend[i] != 0) e.idle = 1'b0;
        e.uf = m_uf;
        q.push_back(e);
        if (do_edge && lock) begin
            if (we) begin
                if (m_pend[w] == 0) m_uf = 1'b1;
                else m_pend[w] = m_pend[w] - 1;
                m_reg[w] = bus.I_WriteBackData;
            end
            if (e.accept && bus.I_DestValid)
                m_pend[d] = m_pend[d] + 1;
        end
    endtask

    task automatic cyc(
        input logic        lk,
        input logic        wbe,
        input logic [3:0]  wbi,
        input logic [15:0] wbd,
        input logic        iv,
        input logic        s1v,
        input logic [3:0]  s1,
        input logic        s2v,
        input logic [3:0]  s2,
        input logic        dv,
        input logic [3:0]  di
    );
        @(posedge clk);
        #1;
        rst_n                 = 1'b1;
        lock                  = lk;
        bus.I_WriteBackEnable = wbe;
        bus.I_WriteBackRegIdx = wbi;
        bus.I_WriteBackData   = wbd;
        bus.I_IssueValid      = iv;
        bus.I_Src1Valid       = s1v;
        bus.I_Src1Idx         = s1;
        bus.I_Src2Valid       = s2v;
        bus.I_Src2Idx         = s2;
        bus.I_DestValid       = dv;
        bus.I_DestIdx         = di;
        predict_and_advance(1'b1);
    endtask

    task automatic mid_reset(input logic [3:0] s1, input logic [3:0] s2);
        @(posedge clk);
        #1;
        lock                  = 1'b1;
        bus.I_WriteBackEnable = 1'b0;
        bus.I_IssueValid      = 1'b1;
        bus.I_Src1Valid       = 1'b1;
        bus.I_Src1Idx         = s1;
        bus.I_Src2Valid       = 1'b1;
        bus.I_Src2Idx         = s2;
        bus.I_DestValid       = 1'b0;
        bus.I_DestIdx         = 4'd0;
        #2;
        rst_n = 1'b0;
        model_clear();
        predict_and_advance(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        lock  = 1'b0;
        bus.I_WriteBackEnable = 1'b0;
        bus.I_WriteBackRegIdx = '0;
        bus.I_WriteBackData   = '0;
        bus.I_IssueValid      = 1'b0;
        bus.I_Src1Valid       = 1'b0;
        bus.I_Src1Idx         = '0;
        bus.I_Src2Valid       = 1'b0;
        bus.I_Src2Idx         = '0;
        bus.I_DestValid       = 1'b0;
        bus.I_DestIdx         = '0;
        model_clear();
        repeat (2) @(posedge clk);

        // reset state: r3/r7 read zero, idle, no stall
        cyc(1, 0, 0, 16'h0, 1, 1, 3, 1, 7, 0, 0);
        // dest r2 accepted, then consumer of r2 stalls
        cyc(1, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 2);
        cyc(1, 0, 0, 16'h0, 1, 1, 2, 0, 0, 0, 0);
        // final commit releases stall with bypassed data
        cyc(1, 1, 2, 16'h00A5, 1, 1, 2, 0, 0, 0, 0);
        cyc(1, 0, 0, 16'h0, 1, 1, 2, 1, 2, 0, 0);
        // saturate r5
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 5);
        cyc(1, 1, 5, 16'h0055, 1, 0, 0, 0, 0, 1, 5);
        cyc(1, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 5);
        // underflow on r9, sticky over idle cycles
        cyc(1, 1, 9, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(1, 0, 0, 16'h0, 0, 1, 9, 0, 0, 0, 0);
        // frozen while lock is low
        cyc(0, 1, 1, 16'hFFFF, 1, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 16'h0, 1, 1, 1, 1, 5, 0, 0);
        // async reset with pend[r4]=2
        cyc(1, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 4);
        cyc(1, 0, 0, 16'h0, 1, 0, 0, 0, 0, 1, 4);
        cyc(1, 0, 0, 16'h0, 1, 1, 4, 0, 0, 0, 0);
        mid_reset(4'd9, 4'd2);
        cyc(1, 1, 4, 16'hBEEF, 1, 1, 4, 1, 9, 0, 0);

        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 2) == 0,
                4'($urandom_range(0, 15)),
                16'($urandom),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge clk);
        ntests++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
